// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared encodings for the floor request scheduler
package elevator_pkg;

  localparam int FLOORS_DEF = 5;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_DOOR = 2'd1,
    ST_UP   = 2'd2,
    ST_DOWN = 2'd3
  } motion_state_e;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_e;

endpackage

// File: rtl/request_latch.sv
// rtl/request_latch.sv - per-bit rising-edge capture into a pending register, clear wins over set
module request_latch #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_enable,
  input  logic [W-1:0] i_btn,
  input  logic [W-1:0] i_clr,
  output logic [W-1:0] o_pend,
  output logic [W-1:0] o_reopen
);

  logic [W-1:0] r_hist;
  logic [W-1:0] r_pend;
  logic [W-1:0] w_edge;

  assign w_edge   = i_btn & ~r_hist;
  // An edge that lands on a bit being cleared is reported so the door can reopen.
  assign o_reopen = i_enable ? (w_edge & i_clr) : '0;
  assign o_pend   = r_pend;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hist <= '0;
      r_pend <= '0;
    end else begin
      r_hist <= i_btn;
      if (i_enable) begin
        r_pend <= (r_pend | w_edge) & ~i_clr;
      end
    end
  end

endmodule

// File: rtl/floor_request_scheduler.sv
// rtl/floor_request_scheduler.sv - SCAN direction FSM and registered destination for car/hall calls
module floor_request_scheduler
  import elevator_pkg::*;
#(
  parameter int FLOORS = FLOORS_DEF,
  parameter int LOC_W  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic [FLOORS-1:0] btn_car,
  input  logic [FLOORS-1:0] btn_up,
  input  logic [FLOORS-1:0] btn_dn,
  input  logic [1:0]        state,
  input  logic [LOC_W-1:0]  location,
  output logic [LOC_W-1:0]  dest,
  output logic              dest_valid,
  output logic [1:0]        dir,
  output logic              open_req,
  output logic [FLOORS-1:0] lamp_car,
  output logic [FLOORS-1:0] lamp_up,
  output logic [FLOORS-1:0] lamp_dn
);

  localparam logic [FLOORS-1:0] UP_MASK = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DN_MASK = {{(FLOORS-1){1'b1}}, 1'b0};

  dir_e             r_dir;
  logic [LOC_W-1:0] r_dest;
  logic             r_dest_valid;
  logic             r_open_req;

  logic              w_loc_ok, w_stop, w_moving, w_open;
  logic [FLOORS-1:0] w_at_l, w_any;
  logic [FLOORS-1:0] w_clr_car, w_clr_up, w_clr_dn;
  logic [FLOORS-1:0] w_pend_car, w_pend_up, w_pend_dn;
  logic [FLOORS-1:0] w_reo_car, w_reo_up, w_reo_dn;
  logic              w_above, w_below;
  logic              w_up_near_ok, w_up_far_ok, w_dn_near_ok, w_dn_far_ok;
  logic [LOC_W-1:0]  w_up_near, w_up_far, w_dn_near, w_dn_far;
  dir_e              w_dir_nxt;
  logic [LOC_W-1:0]  w_dest_nxt;

  assign w_loc_ok = (location != '0) && (location <= LOC_W'(FLOORS));
  assign w_moving = (state == ST_UP) || (state == ST_DOWN);
  assign w_stop   = enable && !w_moving && w_loc_ok;

  always_comb begin
    w_at_l = '0;
    for (int i = 0; i < FLOORS; i++) begin
      w_at_l[i] = (LOC_W'(i + 1) == location);
    end
  end

  // Hall calls for the opposite travel direction stay latched while passing through.
  assign w_clr_car = w_stop ? w_at_l : '0;
  assign w_clr_up  = (w_stop && r_dir != DIR_DN) ? w_at_l : '0;
  assign w_clr_dn  = (w_stop && r_dir != DIR_UP) ? w_at_l : '0;

  request_latch #(.W(FLOORS)) u_car (
    .clk(clk), .resetn(resetn), .i_enable(enable), .i_btn(btn_car),
    .i_clr(w_clr_car), .o_pend(w_pend_car), .o_reopen(w_reo_car)
  );

  request_latch #(.W(FLOORS)) u_up (
    .clk(clk), .resetn(resetn), .i_enable(enable), .i_btn(btn_up & UP_MASK),
    .i_clr(w_clr_up), .o_pend(w_pend_up), .o_reopen(w_reo_up)
  );

  request_latch #(.W(FLOORS)) u_dn (
    .clk(clk), .resetn(resetn), .i_enable(enable), .i_btn(btn_dn & DN_MASK),
    .i_clr(w_clr_dn), .o_pend(w_pend_dn), .o_reopen(w_reo_dn)
  );

  assign w_any  = w_pend_car | w_pend_up | w_pend_dn;
  assign w_open = |((w_pend_car & w_clr_car) | (w_pend_up & w_clr_up) | (w_pend_dn & w_clr_dn)
                    | w_reo_car | w_reo_up | w_reo_dn);

  always_comb begin
    w_above      = 1'b0;
    w_below      = 1'b0;
    w_up_near_ok = 1'b0;
    w_up_far_ok  = 1'b0;
    w_dn_near_ok = 1'b0;
    w_dn_far_ok  = 1'b0;
    w_up_near    = r_dest;
    w_up_far     = r_dest;
    w_dn_near    = r_dest;
    w_dn_far     = r_dest;
    // Descending scan: the last hit is the lowest matching floor.
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (LOC_W'(i + 1) > location && (w_pend_car[i] || w_pend_up[i])) begin
        w_up_near_ok = 1'b1;
        w_up_near    = LOC_W'(i + 1);
      end
      if (LOC_W'(i + 1) < location && w_pend_up[i]) begin
        w_dn_far_ok = 1'b1;
        w_dn_far    = LOC_W'(i + 1);
      end
    end
    // Ascending scan: the last hit is the highest matching floor.
    for (int i = 0; i < FLOORS; i++) begin
      if (LOC_W'(i + 1) > location && w_any[i]) w_above = 1'b1;
      if (LOC_W'(i + 1) < location && w_any[i]) w_below = 1'b1;
      if (LOC_W'(i + 1) > location && w_pend_dn[i]) begin
        w_up_far_ok = 1'b1;
        w_up_far    = LOC_W'(i + 1);
      end
      if (LOC_W'(i + 1) < location && (w_pend_car[i] || w_pend_dn[i])) begin
        w_dn_near_ok = 1'b1;
        w_dn_near    = LOC_W'(i + 1);
      end
    end
  end

  always_comb begin
    w_dir_nxt = r_dir;
    if (w_stop) begin
      case (r_dir)
        DIR_IDLE: begin
          if (w_above)      w_dir_nxt = DIR_UP;
          else if (w_below) w_dir_nxt = DIR_DN;
        end
        DIR_UP:   if (!w_above) w_dir_nxt = w_below ? DIR_DN : DIR_IDLE;
        DIR_DN:   if (!w_below) w_dir_nxt = w_above ? DIR_UP : DIR_IDLE;
        default:  w_dir_nxt = DIR_IDLE;
      endcase
    end
  end

  always_comb begin
    w_dest_nxt = r_dest;
    case (w_dir_nxt)
      DIR_UP: begin
        if (w_up_near_ok)     w_dest_nxt = w_up_near;
        else if (w_up_far_ok) w_dest_nxt = w_up_far;
      end
      DIR_DN: begin
        if (w_dn_near_ok)     w_dest_nxt = w_dn_near;
        else if (w_dn_far_ok) w_dest_nxt = w_dn_far;
      end
      default: w_dest_nxt = location;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dir        <= DIR_IDLE;
      r_dest       <= LOC_W'(1);
      r_dest_valid <= 1'b0;
      r_open_req   <= 1'b0;
    end else begin
      r_dir      <= w_dir_nxt;
      r_open_req <= w_open;
      if (enable) begin
        r_dest_valid <= |w_any;
        // Once arrived at dest while still moving, the target is frozen for the stop.
        if (w_loc_ok && !(w_moving && r_dest == location)) begin
          r_dest <= w_dest_nxt;
        end
      end
    end
  end

  assign dest       = r_dest;
  assign dest_valid = r_dest_valid;
  assign dir        = r_dir;
  assign open_req   = r_open_req;
  assign lamp_car   = w_pend_car;
  assign lamp_up    = w_pend_up;
  assign lamp_dn    = w_pend_dn;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// tb/tb_floor_request_scheduler.sv - scoreboard bench for floor_request_scheduler (5- and 8-floor builds)
module tb_floor_request_scheduler;

  logic       clk = 1'b0;
  logic       resetn;
  logic       enable;
  logic [4:0] btn_car, btn_up, btn_dn;
  logic [1:0] state;
  logic [3:0] location;
  logic [3:0] dest;
  logic       dest_valid, open_req;
  logic [1:0] dir;
  logic [4:0] lamp_car, lamp_up, lamp_dn;

  logic [7:0] b_btn_car, b_btn_up, b_btn_dn;
  logic [1:0] b_state;
  logic [3:0] b_location;
  logic [3:0] b_dest;
  logic       b_dest_valid, b_open_req;
  logic [1:0] b_dir;
  logic [7:0] b_lamp_car, b_lamp_up, b_lamp_dn;

  always #5 clk = ~clk;

  floor_request_scheduler #(.FLOORS(5), .LOC_W(4)) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .btn_car(btn_car), .btn_up(btn_up), .btn_dn(btn_dn),
    .state(state), .location(location),
    .dest(dest), .dest_valid(dest_valid), .dir(dir), .open_req(open_req),
    .lamp_car(lamp_car), .lamp_up(lamp_up), .lamp_dn(lamp_dn)
  );

  floor_request_scheduler #(.FLOORS(8), .LOC_W(4)) dut8 (
    .clk(clk), .resetn(resetn), .enable(enable),
    .btn_car(b_btn_car), .btn_up(b_btn_up), .btn_dn(b_btn_dn),
    .state(b_state), .location(b_location),
    .dest(b_dest), .dest_valid(b_dest_valid), .dir(b_dir), .open_req(b_open_req),
    .lamp_car(b_lamp_car), .lamp_up(b_lamp_up), .lamp_dn(b_lamp_dn)
  );

  localparam int K_DEST = 0, K_VALID = 1, K_DIR = 2, K_OPEN = 3;
  localparam int K_LCAR = 4, K_LUP = 5, K_LDN = 6;
  localparam int K8_DEST = 7, K8_VALID = 8, K8_DIR = 9, K8_OPEN = 10, K8_LCAR = 11;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_DEST:   return 32'(dest);
      K_VALID:  return 32'(dest_valid);
      K_DIR:    return 32'(dir);
      K_OPEN:   return 32'(open_req);
      K_LCAR:   return 32'(lamp_car);
      K_LUP:    return 32'(lamp_up);
      K_LDN:    return 32'(lamp_dn);
      K8_DEST:  return 32'(b_dest);
      K8_VALID: return 32'(b_dest_valid);
      K8_DIR:   return 32'(b_dir);
      K8_OPEN:  return 32'(b_open_req);
      K8_LCAR:  return 32'(b_lamp_car);
      default:  return 32'hdead_beef;
    endcase
  endfunction

  task automatic sb_push(input string tag, input int kind, input logic [31:0] exp);
    sb_item_t it;
    it.tag  = tag;
    it.kind = kind;
    it.exp  = exp;
    sb.push_back(it);
  endtask

  task automatic sb_drain();
    sb_item_t it;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      check_val(it.tag, observe(it.kind), it.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b1;
    btn_car = '0; btn_up = '0; btn_dn = '0; state = 2'd0; location = 4'd1;
    b_btn_car = '0; b_btn_up = '0; b_btn_dn = '0; b_state = 2'd0; b_location = 4'd4;
    tick(); tick();
    sb_push("rst_dest", K_DEST, 1);   sb_push("rst_valid", K_VALID, 0);
    sb_push("rst_dir", K_DIR, 0);     sb_push("rst_open", K_OPEN, 0);
    sb_push("rst_lcar", K_LCAR, 0);   sb_push("rst_lup", K_LUP, 0);
    sb_push("rst_ldn", K_LDN, 0);
    sb_drain();
    resetn = 1'b1;
    tick();

    // idle at floor 1, car call to floor 4
    btn_car = 5'b01000; tick();
    sb_push("a_lcar", K_LCAR, 5'b01000); sb_drain();
    btn_car = '0; tick();
    sb_push("a_dir", K_DIR, 1); sb_push("a_dest", K_DEST, 4); sb_push("a_valid", K_VALID, 1);
    sb_drain();

    // moving up at floor 2: up call and car call at 3, down call at 2
    state = 2'd2; location = 4'd2;
    btn_up = 5'b00100; btn_car = 5'b00100; btn_dn = 5'b00010; tick();
    btn_up = '0; btn_car = '0; btn_dn = '0; tick();
    sb_push("b_dest", K_DEST, 3);        sb_push("b_lup", K_LUP, 5'b00100);
    sb_push("b_ldn", K_LDN, 5'b00010);   sb_push("b_lcar", K_LCAR, 5'b01100);
    sb_push("b_open", K_OPEN, 0);        sb_push("b_dir", K_DIR, 1);
    sb_drain();

    // stop at floor 3 going up
    location = 4'd3; state = 2'd0; tick();
    sb_push("c_open", K_OPEN, 1);        sb_push("c_lcar", K_LCAR, 5'b01000);
    sb_push("c_lup", K_LUP, 0);          sb_push("c_ldn", K_LDN, 5'b00010);
    sb_push("c_dir", K_DIR, 1);          sb_push("c_dest", K_DEST, 4);
    sb_drain();
    tick();
    sb_push("c_open_once", K_OPEN, 0); sb_drain();

    // door open at 3, car button for 3 pressed: reopen, lamp stays dark
    state = 2'd1; btn_car = 5'b00100; tick();
    sb_push("d_lcar", K_LCAR, 5'b01000); sb_push("d_open", K_OPEN, 1); sb_drain();
    btn_car = '0; tick();
    sb_push("d_open_once", K_OPEN, 0); sb_drain();

    // continue up to 4, then stop with only the down call at 2 left
    state = 2'd2; location = 4'd4; tick();
    sb_push("e_dest_hold", K_DEST, 4); sb_push("e_ldn_kept", K_LDN, 5'b00010); sb_drain();
    state = 2'd0; tick();
    sb_push("e_dir", K_DIR, 2);     sb_push("e_dest", K_DEST, 2);
    sb_push("e_lcar", K_LCAR, 0);   sb_push("e_open", K_OPEN, 1);
    sb_push("e_ldn", K_LDN, 5'b00010);
    sb_drain();

    // enable low: edges discarded; held button does not set later
    enable = 1'b0; btn_car = 5'b10000; tick(); tick();
    sb_push("f_lcar_dis", K_LCAR, 0); sb_push("f_dest_hold", K_DEST, 2); sb_push("f_dir_hold", K_DIR, 2);
    sb_drain();
    enable = 1'b1; tick();
    sb_push("f_lcar_held", K_LCAR, 0); sb_drain();
    btn_car = '0;

    // serve the down call at floor 2
    location = 4'd2; tick();
    sb_push("g_ldn", K_LDN, 0); sb_push("g_dir", K_DIR, 0);
    sb_push("g_open", K_OPEN, 1); sb_push("g_dest", K_DEST, 2);
    sb_drain();
    tick();
    sb_push("g_valid", K_VALID, 0); sb_push("g_open_once", K_OPEN, 0); sb_drain();

    // out-of-range location: request latched, nothing cleared, dest holds
    location = 4'd0; btn_car = 5'b00001; tick();
    sb_push("h_lcar", K_LCAR, 5'b00001); sb_push("h_open", K_OPEN, 0); sb_push("h_dest", K_DEST, 2);
    sb_drain();
    btn_car = '0; location = 4'd1; tick();
    sb_push("h_open_l1", K_OPEN, 1); sb_push("h_lcar_clr", K_LCAR, 0); sb_push("h_dest_l1", K_DEST, 1);
    sb_drain();

    // 8-floor build: calls at 1 and 8 from idle at 4
    b_btn_car = 8'h81; tick();
    b_btn_car = '0; tick();
    sb_push("p_dir", K8_DIR, 1); sb_push("p_dest", K8_DEST, 8); sb_push("p_lcar", K8_LCAR, 8'h81);
    sb_drain();
    b_state = 2'd2;
    for (int f = 5; f <= 8; f++) begin
      b_location = 4'(f);
      tick();
    end
    b_state = 2'd0; tick();
    sb_push("p_dir_dn", K8_DIR, 2); sb_push("p_dest_1", K8_DEST, 1); sb_push("p_lcar_8", K8_LCAR, 8'h01);
    sb_drain();
    b_state = 2'd3; b_location = 4'd7; tick();

    // asynchronous reset mid-travel, checked before any clock edge
    #2 resetn = 1'b0;
    #1;
    sb_push("q_dest", K8_DEST, 1);  sb_push("q_dir", K8_DIR, 0);
    sb_push("q_valid", K8_VALID, 0); sb_push("q_lcar", K8_LCAR, 0);
    sb_push("q_open", K8_OPEN, 0);
    sb_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
